span_fill_writer: RTL and testbench
===================================

# span_fill_writer

Downstream stage of the fill controller: on `fill_start`, writes one horizontal span of a solid colour into the frame buffer, one pixel per write handshake, then pulses `fill_done`. Inputs are the row (`row_y`) and edge bounds (`x_left`, `x_right`) produced by the row stage, plus the fill colour. Spans are clipped to the screen, and frame-buffer addresses are generated internally.

## Interface
- `SCREEN_W`, 640: pixels per row
- `SCREEN_H`, 480: rows
- `XW`, 10: x coordinate width
- `YW`, 9: y coordinate width
- `COLOR_W`, 24: pixel colour width
- `ADDR_W`, 19: frame-buffer word address width (one pixel per word)

Ports:
- `clk`  in  1  system clock, rising edge
- `n_rst`  in  1  reset, asynchronous, active-low
- `fill_start`  in  1  level request from the fill controller; held high until `fill_done` is seen
- `row_y`  in  YW  span row; sampled in the start cycle
- `x_left`  in  XW  first pixel, inclusive; sampled in the start cycle
- `x_right`  in  XW  last pixel, inclusive; sampled in the start cycle
- `fill_color`  in  COLOR_W  colour; sampled in the start cycle
- `wr_ack`  in  1  frame buffer accepted the current write
- `wr_en`  out  1  write request
- `wr_addr`  out  ADDR_W  pixel address, `row_y*SCREEN_W + x`
- `wr_data`  out  COLOR_W  pixel colour
- `busy`  out  1  high in every state except IDLE
- `fill_done`  out  1  one-cycle pulse when the span is complete
- `pix_count`  out  XW+1  pixels written in the last span; held until the next start

## Operation
- Reset value of every output is 0. State is IDLE and `armed` is 0.
- `armed` flag: set in any cycle where `fill_start` is low; cleared on acceptance. A start is accepted only when IDLE, `fill_start` is high and `armed` is 1. This stops a request still held high from re-triggering.
- IDLE → LOAD on an accepted start; all inputs are latched in that cycle.
- LOAD (1 cycle):
  - `xe = min(x_right, SCREEN_W-1)`.
  - Compute `base = row_y*SCREEN_W` as a registered product.
  - Clear `pix_count`.
  - If `row_y >= SCREEN_H` or `x_left > xe` (empty or fully clipped span) → DONE; otherwise → WRITE with `x = x_left`.
- WRITE:
  - Drive `wr_en` = 1, `wr_addr = base + x`, `wr_data` = colour.
  - Address and data stay stable while `wr_ack` = 0.
  - On `wr_ack` = 1: increment `pix_count`. If `x == xe` → DONE; else `x` increments and the next pixel is driven in the following cycle with `wr_en` still high.
- DONE: `fill_done` = 1 for exactly 1 cycle, `wr_en` = 0 → IDLE.
- Arithmetic is unsigned. The `x` counter is XW+1 bits so `xe = SCREEN_W-1` cannot wrap.
- `fill_start` dropping mid-span has no effect; the span always completes.
- Reset mid-span abandons the span immediately; no `fill_done` is produced.

## Timing
- Start accepted at edge 0: LOAD in cycle 1, first `wr_en` in cycle 2.
- N-pixel span with `wr_ack` tied high:
  - `wr_en` high cycles 2..N+1.
  - `fill_done` in cycle N+2.
  - Throughput is 1 pixel per clock.
- Each ack-low cycle delays all later events by 1 cycle.
- Empty or clipped span: `fill_done` in cycle 2, no writes.
- `wr_ack` is ignored whenever `wr_en` = 0.
- Minimum re-start: `fill_start` must be low for at least 1 cycle after `fill_done`.

## Structure
- Shared package `fill_pkg`:
  - state enum `span_state_t` {IDLE, LOAD, WRITE, DONE}
  - `SCREEN_W` and `SCREEN_H` defaults
  - coordinate typedefs `x_t` and `y_t`
- Sub-module `span_addr_gen` holds the x counter, `base` register, address adder and last-pixel compare. The top level holds the FSM, `armed` and the output registers.

## Test plan
- `row_y`=10, `x_left`=5, `x_right`=8, `wr_ack`=1 → 4 writes at addresses 6405..6408, `fill_done` in cycle 6, `pix_count`=4.
- Same span, `wr_ack` low for 2 cycles on the second pixel → address 6406 held for 3 cycles, `fill_done` in cycle 8, no duplicate or skipped address.
- `x_left`=630, `x_right`=700, `row_y`=0 → clipped to 630..639 (10 writes); `row_y`=480 → no writes, `fill_done` in cycle 2, `pix_count`=0.
- `x_left`=9, `x_right`=3 → no writes, `fill_done` in cycle 2; `fill_start` held high for 5 cycles after `fill_done` → no second span until it drops and rises again.
- `n_rst` asserted during the third pixel of a 10-pixel span → all outputs 0 asynchronously, no `fill_done`; after release with `fill_start` high, no start until `fill_start` has gone low.

Source files
------------

// File: rtl/fill_pkg.sv
// Shared types and screen geometry for the span fill datapath.
package fill_pkg;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;
  localparam int unsigned XW           = 10;
  localparam int unsigned YW           = 9;
  localparam int unsigned COLOR_W      = 24;
  localparam int unsigned ADDR_W       = 19;

  typedef logic [XW-1:0]      x_t;
  typedef logic [XW:0]        xc_t;
  typedef logic [YW-1:0]      y_t;
  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } span_state_t;

endpackage

// File: rtl/span_addr_gen.sv
// Span address generator: latches coordinates, clips the right edge, walks x
// and forms the frame-buffer address from a registered row base.
module span_addr_gen
  import fill_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic  clk,
  input  logic  n_rst,
  input  logic  i_capture,
  input  y_t    i_row_y,
  input  x_t    i_x_left,
  input  x_t    i_x_right,
  input  logic  i_load,
  input  logic  i_step,
  output addr_t o_addr,
  output logic  o_empty_c,
  output logic  o_last_c
);

  addr_t r_base;
  x_t    r_x_left;
  x_t    r_x_right;
  logic  r_row_ok;
  xc_t   r_x;
  xc_t   r_xe;
  addr_t r_addr;

  xc_t   w_xe;
  xc_t   w_x_inc;

  // Right edge clipped to the last on-screen column.
  assign w_xe = (xc_t'(r_x_right) > xc_t'(SCREEN_W - 1)) ? xc_t'(SCREEN_W - 1)
                                                          : xc_t'(r_x_right);
  assign w_x_inc   = r_x + xc_t'(1);
  assign o_empty_c = !r_row_ok || (xc_t'(r_x_left) > w_xe);
  assign o_last_c  = (r_x == r_xe);
  assign o_addr    = r_addr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_base    <= '0;
      r_x_left  <= '0;
      r_x_right <= '0;
      r_row_ok  <= 1'b0;
      r_x       <= '0;
      r_xe      <= '0;
      r_addr    <= '0;
    end else begin
      if (i_capture) begin
        r_base    <= addr_t'(i_row_y) * addr_t'(SCREEN_W);
        r_x_left  <= i_x_left;
        r_x_right <= i_x_right;
        r_row_ok  <= (32'(i_row_y) < SCREEN_H);
      end
      if (i_load) begin
        r_x    <= xc_t'(r_x_left);
        r_xe   <= w_xe;
        r_addr <= r_base + addr_t'(r_x_left);
      end else if (i_step && !o_last_c) begin
        r_x    <= w_x_inc;
        r_addr <= r_base + addr_t'(w_x_inc);
      end
    end
  end

endmodule

// File: rtl/span_fill_writer.sv
// Writes one clipped horizontal span of a solid colour into the frame buffer,
// one pixel per write handshake, then pulses fill_done.
module span_fill_writer
  import fill_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fill_start,
  input  logic [YW-1:0]      row_y,
  input  logic [XW-1:0]      x_left,
  input  logic [XW-1:0]      x_right,
  input  logic [COLOR_W-1:0] fill_color,
  input  logic               wr_ack,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               busy,
  output logic               fill_done,
  output logic [XW:0]        pix_count
);

  span_state_t r_state;
  span_state_t w_state_nxt;
  logic        r_armed;
  logic        w_accept;
  logic        w_empty;
  logic        w_last;

  logic        r_wr_en;
  logic        r_busy;
  logic        r_fill_done;
  color_t      r_wr_data;
  xc_t         r_pix_count;

  logic        w_wr_en_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  color_t      w_data_nxt;
  xc_t         w_pix_nxt;

  // A held-high request must drop at least once before it can start a span.
  assign w_accept = (r_state == IDLE) && fill_start && r_armed;

  span_addr_gen #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_addr_gen (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_capture (w_accept),
    .i_row_y   (row_y),
    .i_x_left  (x_left),
    .i_x_right (x_right),
    .i_load    (r_state == LOAD),
    .i_step    ((r_state == WRITE) && wr_ack),
    .o_addr    (wr_addr),
    .o_empty_c (w_empty),
    .o_last_c  (w_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = w_empty ? DONE : WRITE;
      WRITE:   if (wr_ack && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_wr_en_nxt = (w_state_nxt == WRITE);
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_done_nxt  = (w_state_nxt == DONE);
    w_data_nxt  = w_accept ? fill_color : r_wr_data;
    w_pix_nxt   = r_pix_count;
    if (r_state == LOAD) begin
      w_pix_nxt = '0;
    end else if ((r_state == WRITE) && wr_ack) begin
      w_pix_nxt = r_pix_count + xc_t'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_armed     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_fill_done <= 1'b0;
      r_wr_data   <= '0;
      r_pix_count <= '0;
    end else begin
      if (!fill_start)   r_armed <= 1'b1;
      else if (w_accept) r_armed <= 1'b0;
      r_wr_en     <= w_wr_en_nxt;
      r_busy      <= w_busy_nxt;
      r_fill_done <= w_done_nxt;
      r_wr_data   <= w_data_nxt;
      r_pix_count <= w_pix_nxt;
    end
  end

  assign wr_en     = r_wr_en;
  assign busy      = r_busy;
  assign fill_done = r_fill_done;
  assign wr_data   = r_wr_data;
  assign pix_count = r_pix_count;

endmodule

// File: tb/tb_span_fill_writer.sv
// Scoreboard bench for span_fill_writer: expected pixel writes and done
// records are queued at stimulus time and checked by an independent monitor.
module tb_span_fill_writer;
  import fill_pkg::*;

  logic   clk = 1'b0;
  logic   n_rst;
  logic   fill_start;
  y_t     row_y;
  x_t     x_left;
  x_t     x_right;
  color_t fill_color;
  logic   wr_ack;
  logic   wr_en;
  addr_t  wr_addr;
  color_t wr_data;
  logic   busy;
  logic   fill_done;
  xc_t    pix_count;

  always #5 clk = ~clk;

  span_fill_writer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .fill_start (fill_start),
    .row_y      (row_y),
    .x_left     (x_left),
    .x_right    (x_right),
    .fill_color (fill_color),
    .wr_ack     (wr_ack),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .fill_done  (fill_done),
    .pix_count  (pix_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int stall_cnt = 0;
  int ack_pct = 100;
  int stall_pix = -1;
  int stall_len = 0;
  int stall_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"},     32'(wr_en),     0);
    chk({tag, "_wr_addr"},   32'(wr_addr),   0);
    chk({tag, "_wr_data"},   32'(wr_data),   0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_fill_done"}, 32'(fill_done), 0);
    chk({tag, "_pix_count"}, 32'(pix_count), 0);
  endtask

  // Monitor: every driven write must match the head of the expected queue;
  // the head is only retired on a handshake, so stalls must hold it.
  always @(negedge clk) begin
    if (n_rst) begin
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write: got addr %0d, none expected", wr_addr);
        end else begin
          chk("wr_addr", 32'(wr_addr), exp_wr[0].addr);
          chk("wr_data", 32'(wr_data), exp_wr[0].data);
          if (wr_ack) begin
            void'(exp_wr.pop_front());
            hs_cnt++;
          end else begin
            stall_cnt++;
          end
        end
      end
      if (fill_done) begin
        if (exp_done.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got fill_done, none expected");
        end else begin
          chk("pix_count", 32'(pix_count), 32'(exp_done.pop_front()));
          chk("writes_left_at_done", 32'(exp_wr.size()), 0);
        end
      end
    end
  end

  // Write-ack driver: optional scripted stall on one pixel, otherwise random.
  initial begin
    wr_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wr_en && stall_pix == hs_cnt && stall_done < stall_len) begin
        wr_ack = 1'b0;
        stall_done++;
      end else if (!wr_en) begin
        wr_ack = 1'($urandom_range(1));
      end else begin
        wr_ack = (int'($urandom_range(99)) < ack_pct);
      end
    end
  end

  // Reference: clip to the screen and list every pixel address in the span.
  task automatic run_span(input int ry, input int xl, input int xr,
                          input int exp_lat, input int hold, input bit drop);
    int     xe;
    int     n;
    int     c;
    color_t col;
    col = color_t'($urandom);
    xe  = (xr > 639) ? 639 : xr;
    n   = 0;
    if (ry < 480 && xl <= xe) begin
      for (int x = xl; x <= xe; x++) begin
        exp_wr.push_back('{32'(ry * 640 + x), 32'(col)});
        n++;
      end
    end
    exp_done.push_back(n);
    @(posedge clk); #1;
    hs_cnt = 0; stall_cnt = 0; stall_done = 0;
    row_y = y_t'(ry); x_left = x_t'(xl); x_right = x_t'(xr);
    fill_color = col; fill_start = 1'b1;
    @(posedge clk); #1;
    row_y = y_t'($urandom); x_left = x_t'($urandom); x_right = x_t'($urandom);
    fill_color = color_t'($urandom);
    if (drop) fill_start = 1'b0;
    c = 1;
    while (c < 3000) begin
      @(negedge clk);
      if (fill_done) break;
      @(posedge clk); #1;
      c++;
    end
    if (c >= 3000) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no fill_done within %0d cycles", c);
    end else begin
      chk("done_busy",  32'(busy),  1);
      chk("done_wr_en", 32'(wr_en), 0);
      chk("done_cycle", 32'(c), 32'((exp_lat >= 0) ? exp_lat : 2 + n + stall_cnt));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_busy",  32'(busy),  0);
      chk("hold_wr_en", 32'(wr_en), 0);
    end
    @(posedge clk); #1;
    fill_start = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; fill_start = 1'b0; row_y = '0; x_left = '0; x_right = '0;
    fill_color = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    n_rst = 1'b1;

    run_span(10, 5, 8, 6, 0, 1'b0);
    stall_pix = 1; stall_len = 2;
    run_span(10, 5, 8, 8, 0, 1'b0);
    stall_pix = -1; stall_len = 0;
    run_span(0, 630, 700, 12, 0, 1'b0);
    run_span(480, 5, 8, 2, 0, 1'b0);
    run_span(9, 9, 3, 2, 5, 1'b0);
    run_span(479, 639, 639, 3, 0, 1'b0);
    run_span(12, 20, 23, 6, 0, 1'b1);

    // Reset during the third pixel of a 10-pixel span.
    for (int x = 100; x <= 109; x++) exp_wr.push_back('{32'(20 * 640 + x), 32'h00abcdef});
    @(posedge clk); #1;
    hs_cnt = 0;
    row_y = 9'd20; x_left = 10'd100; x_right = 10'd109; fill_color = 24'habcdef;
    fill_start = 1'b1;
    for (int i = 0; i < 40 && hs_cnt < 2; i++) @(negedge clk);
    if (hs_cnt < 2) begin
      n_cmp++; n_err++;
      $display("FAIL reset_span_progress: got %0d pixels expected 2", hs_cnt);
    end
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    chk_all_zero("rst_async");
    exp_wr.delete();
    @(negedge clk);
    n_rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_busy",  32'(busy),  0);
      chk("post_rst_wr_en", 32'(wr_en), 0);
    end
    @(posedge clk); #1;
    fill_start = 1'b0;
    run_span(20, 100, 109, 12, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int ry;
      int xl;
      int xr;
      ry = int'($urandom_range(499));
      xl = int'($urandom_range(700));
      xr = xl + int'($urandom_range(30)) - 4;
      if (xr < 0) xr = 0;
      ack_pct = int'($urandom_range(100, 40));
      run_span(ry, xl, xr, -1, int'($urandom_range(2)), ($urandom_range(3) == 0));
    end

    repeat (3) @(negedge clk);
    chk("final_wr_queue",   32'(exp_wr.size()),   0);
    chk("final_done_queue", 32'(exp_done.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
